// File: rtl/tc_sram_init_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tc_sram_init_ctrl_pkg
// Width helpers for the SRAM init controller. They match the way tc_sram
// derives its own address and byte-enable widths, so the two blocks always
// agree on port sizes when given the same NumWords/DataWidth/ByteWidth.
// -----------------------------------------------------------------------------
package tc_sram_init_ctrl_pkg;

   // A single-word memory still needs a 1-bit address port.
   function automatic int unsigned addr_width(input int unsigned num_words);
      return (num_words > 32'd1) ? unsigned'($clog2(num_words)) : 32'd1;
   endfunction

   // One enable lane per started byte, so partial top bytes still get a lane.
   function automatic int unsigned be_width(input int unsigned data_width,
                                            input int unsigned byte_width);
      return (data_width + byte_width - 32'd1) / byte_width;
   endfunction

endpackage

// File: rtl/tc_sram_init_ctrl.sv
// -----------------------------------------------------------------------------
// tc_sram_init_ctrl
// Front end for a single-port, latency-1 tc_sram. After reset (or when asked)
// it sweeps every word and writes InitValue so no stale/X data can reach the
// core, then forwards an OBI-style req/gnt/rvalid port straight to the macro.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   init_start_i          pulse: (re)start the init sweep
//   init_done_o           high while READY (sweep complete)
//   req_i/we_i/addr_i/wdata_i/be_i   bus request from the core
//   gnt_o                 grant, combinational, high only in READY
//   rvalid_o/rdata_o      response one cycle after every grant
//   sram_req_o/we_o/addr_o/wdata_o/be_o   drive tc_sram
//   sram_rdata_i          read data from tc_sram
// -----------------------------------------------------------------------------
module tc_sram_init_ctrl
   import tc_sram_init_ctrl_pkg::*;
#(
   parameter int unsigned          NumWords    = 32'd512,
   parameter int unsigned          DataWidth   = 32'd32,
   parameter int unsigned          ByteWidth   = 32'd8,
   parameter logic [DataWidth-1:0] InitValue   = '0,
   parameter bit                   InitOnReset = 1'b1,
   parameter int unsigned          AddrWidth   = addr_width(NumWords),
   parameter int unsigned          BeWidth     = be_width(DataWidth, ByteWidth)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 init_start_i,
   output logic                 init_done_o,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [BeWidth-1:0]   be_i,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   typedef enum logic {
      StInit,
      StReady
   } state_e;

   // The sweep ends on an explicit compare so non-power-of-two depths work.
   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 32'd1);
   localparam state_e ResetState = InitOnReset ? StInit : StReady;

   state_e               state_q;
   logic [AddrWidth-1:0] cnt_q;
   logic                 resp_we_q;
   logic                 granted;

   // Sweep counter and INIT/READY sequencing. A restart request while
   // sweeping takes priority over finishing, so a pulse on the last word
   // still yields a full fresh sweep. init_done_o is registered alongside
   // the state so it is high exactly while READY.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ResetState;
         cnt_q       <= '0;
         init_done_o <= !InitOnReset;
      end else begin
         case (state_q)
            StInit: begin
               if (init_start_i) begin
                  cnt_q <= '0;
               end else if (cnt_q == LastAddr) begin
                  cnt_q       <= '0;
                  state_q     <= StReady;
                  init_done_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + AddrWidth'(1);
               end
            end
            StReady: begin
               if (init_start_i) begin
                  cnt_q       <= '0;
                  state_q     <= StInit;
                  init_done_o <= 1'b0;
               end
            end
            default: begin
               cnt_q       <= '0;
               state_q     <= ResetState;
               init_done_o <= !InitOnReset;
            end
         endcase
      end
   end

   // The controller owns the macro port. While sweeping it writes InitValue
   // to every lane of the current word and refuses the bus; once READY the
   // bus passes straight through, which keeps the read latency at one cycle.
   always_comb begin
      gnt_o        = 1'b1;
      sram_req_o   = req_i;
      sram_we_o    = we_i;
      sram_addr_o  = addr_i;
      sram_wdata_o = wdata_i;
      sram_be_o    = be_i;
      if (state_q == StInit) begin
         gnt_o        = 1'b0;
         sram_req_o   = 1'b1;
         sram_we_o    = 1'b1;
         sram_addr_o  = cnt_q;
         sram_wdata_o = InitValue;
         sram_be_o    = '1;
      end
   end

   assign granted = req_i & gnt_o;

   // Every grant produces exactly one rvalid_o on the following cycle. The
   // request direction is kept so write responses return zero data instead
   // of whatever the macro's read register happens to hold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_o  <= 1'b0;
         resp_we_q <= 1'b0;
      end else begin
         rvalid_o <= granted;
         if (granted) begin
            resp_we_q <= we_i;
         end
      end
   end

   assign rdata_o = (rvalid_o && !resp_we_q) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_tc_sram_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tc_sram_init_ctrl
// Drives the controller in front of a behavioural latency-1 SRAM and compares
// every cycle against a reference model that tracks the expected memory image,
// the sweep position and the pending response. A second instance with three
// words exercises the non-power-of-two sweep termination.
// -----------------------------------------------------------------------------
module tb_tc_sram_init_ctrl;

   localparam int NW = 512;
   localparam logic [31:0] InitVal = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        init_start = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [8:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        init_done, gnt, rvalid;
   logic [31:0] rdata;
   logic        sram_req, sram_we;
   logic [8:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_be;
   logic [31:0] sram_rdata = '0;

   logic        init_done3, gnt3, rvalid3, sram_req3, sram_we3;
   logic [31:0] rdata3, sram_wdata3;
   logic [1:0]  sram_addr3;
   logic [3:0]  sram_be3;
   logic        zero1 = 1'b0;
   logic [1:0]  zero2 = '0;
   logic [3:0]  zero4 = '0;
   logic [31:0] zero32 = '0;

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tc_sram_init_ctrl #(.NumWords(512), .DataWidth(32), .ByteWidth(8),
                       .InitValue(InitVal), .InitOnReset(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .init_start_i(init_start), .init_done_o(init_done),
      .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .rvalid_o(rvalid), .rdata_o(rdata),
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
   );

   tc_sram_init_ctrl #(.NumWords(3), .DataWidth(32), .ByteWidth(8),
                       .InitValue(InitVal), .InitOnReset(1'b1)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .init_start_i(zero1), .init_done_o(init_done3),
      .req_i(zero1), .gnt_o(gnt3), .we_i(zero1), .addr_i(zero2), .wdata_i(zero32), .be_i(zero4),
      .rvalid_o(rvalid3), .rdata_o(rdata3),
      .sram_req_o(sram_req3), .sram_we_o(sram_we3), .sram_addr_o(sram_addr3),
      .sram_wdata_o(sram_wdata3), .sram_be_o(sram_be3), .sram_rdata_i(zero32)
   );

   // Behavioural tc_sram: byte-masked writes, read data registered, writes
   // leave the read register alone. Starts with garbage so the sweep matters.
   logic [31:0] mem [NW];
   initial for (int i = 0; i < NW; i++) mem[i] = $urandom;

   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   // Reference model state: expected memory image, whether a sweep is
   // running and which word it is on, and the response due next cycle.
   logic [31:0] ref_mem [NW];
   bit          m_init;
   int          m_pos;
   bit          exp_rvalid;
   logic [31:0] exp_rdata;
   int          since_rst;

   typedef struct {
      logic        req;
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_rvalid;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_init     = 1'b1;
      m_pos      = 0;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
      since_rst  = 0;
   endtask

   task automatic checkComb();
      logic [63:0] exp_bus;
      logic [63:0] act_bus;
      act_bus = {17'd0, sram_req, sram_we, sram_addr, sram_wdata, sram_be};
      if (m_init) exp_bus = {17'd0, 1'b1, 1'b1, 9'(m_pos), InitVal, 4'hF};
      else        exp_bus = {17'd0, req, we, addr, wdata, be};
      checkValue("gnt", 64'(gnt), 64'(!m_init));
      checkValue("sram_port", act_bus, exp_bus);
      if (since_rst < 3) begin
         checkValue("small_sweep_addr", {62'd0, sram_addr3}, 64'(since_rst));
         checkValue("small_sweep_busy", 64'(init_done3), 64'd0);
      end else if (since_rst == 3) begin
         checkValue("small_sweep_done", 64'(init_done3), 64'd1);
      end
   endtask

   // One clock edge of the abstract model, driven by the current inputs.
   task automatic modelEdge();
      if (!m_init && req) begin
         exp_rvalid = 1'b1;
         exp_rdata  = we ? 32'd0 : ref_mem[addr];
         if (we)
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
         exp_rvalid = 1'b0;
         exp_rdata  = '0;
      end
      if (m_init) begin
         ref_mem[m_pos] = InitVal;
         if (init_start)          m_pos = 0;
         else if (m_pos == NW-1)  begin m_init = 1'b0; m_pos = 0; end
         else                     m_pos++;
      end else if (init_start) begin
         m_init = 1'b1;
         m_pos  = 0;
      end
   endtask

   task automatic checkOutput();
      checkValue("rvalid", 64'(rvalid), 64'(exp_rvalid));
      checkValue("rdata", 64'(rdata), 64'(exp_rdata));
      checkValue("init_done", 64'(init_done), 64'(!m_init));
      since_rst++;
   endtask

   task automatic applyStimulus(input logic r, input logic w, input logic [8:0] a,
                                input logic [31:0] d, input logic [3:0] b, input logic s);
      @(negedge clk);
      req = r; we = w; addr = a; wdata = d; be = b; init_start = s;
      #1;
      checkComb();
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 9'd0, 32'd0, 4'd0, 1'b0);
   endtask

   // Asynchronous reset: outputs must drop at once, release lands just after
   // a rising edge so the next stimulus sees the fresh reset state.
   task automatic doReset();
      rst_n = 1'b0;
      req = 1'b0; init_start = 1'b0;
      #1;
      checkValue("reset_rvalid", 64'(rvalid), 64'd0);
      checkValue("reset_init_done", 64'(init_done), 64'd0);
      checkValue("reset_gnt", 64'(gnt), 64'd0);
      checkValue("reset_addr", 64'(sram_addr), 64'd0);
      modelReset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic waitInit(input int expected);
      int count;
      count = 0;
      while (!init_done && count < 2000) begin
         idle();
         count++;
      end
      checkValue("init_cycles", 64'(count), 64'(expected));
   endtask

   initial begin
      for (int i = 0; i < NW; i++) ref_mem[i] = InitVal;
      vecs[0] = '{1'b1, 1'b0, 9'h1A5, 32'h0,         4'h0, 1'b1, InitVal};
      vecs[1] = '{1'b1, 1'b1, 9'h1A5, 32'hDEADBEEF,  4'b0101, 1'b1, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 9'h1A5, 32'h0,         4'h0, 1'b1, 32'h00AD00EF};
      vecs[3] = '{1'b1, 1'b0, 9'd3,   32'h0,         4'h0, 1'b1, InitVal};
      vecs[4] = '{1'b1, 1'b1, 9'd4,   32'hCAFEF00D,  4'hF, 1'b1, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 9'd3,   32'h0,         4'h0, 1'b1, InitVal};
      vecs[6] = '{1'b1, 1'b0, 9'd4,   32'h0,         4'h0, 1'b1, 32'hCAFEF00D};
      vecs[7] = '{1'b0, 1'b0, 9'd0,   32'h0,         4'h0, 1'b0, 32'h0};

      #1;
      doReset();
      waitInit(NW);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0);
         checkValue($sformatf("vec%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rvalid));
         checkValue($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      end

      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       9'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 299) == 0));
      end
      if (m_init) waitInit(NW - m_pos);

      // Read granted in the same cycle as the restart request.
      applyStimulus(1'b1, 1'b1, 9'd7, 32'h12345678, 4'hF, 1'b0);
      applyStimulus(1'b1, 1'b0, 9'd7, 32'h0, 4'h0, 1'b1);
      checkValue("read_on_restart_rvalid", 64'(rvalid), 64'd1);
      checkValue("read_on_restart_rdata", 64'(rdata), 64'h12345678);
      waitInit(NW);
      for (int a = 0; a < NW; a++) begin
         applyStimulus(1'b1, 1'b0, 9'(a), 32'h0, 4'h0, 1'b0);
         checkValue("word_cleared", 64'(rdata), 64'(InitVal));
      end

      // Restart in the middle of a sweep: 100 INIT cycles, then a full sweep.
      applyStimulus(1'b0, 1'b0, 9'd0, 32'h0, 4'h0, 1'b1);
      for (int i = 0; i < 99; i++) idle();
      applyStimulus(1'b0, 1'b0, 9'd0, 32'h0, 4'h0, 1'b1);
      waitInit(NW);

      // Reset with a read response in flight.
      applyStimulus(1'b1, 1'b0, 9'd5, 32'h0, 4'h0, 1'b0);
      checkValue("pending_rvalid", 64'(rvalid), 64'd1);
      doReset();

      // Reset in the middle of a sweep.
      for (int i = 0; i < 300; i++) idle();
      checkValue("pre_reset_addr", 64'(sram_addr), 64'd300);
      doReset();
      waitInit(NW);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
